load_store_unit: RTL and testbench

Memory-stage initiator that drives the data memory's read/write port on behalf of the pipeline. Accepts one load or store per request, turns it into word-aligned memory transactions, performs read-modify-write for byte/halfword stores, and returns sign- or zero-extended load data. Sits between the MEM pipeline stage and `DataMemory`. It holds the stage busy via `ReqReady` until the response is issued.

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 44 ++++
 rtl/load_store_unit.sv | 135 +++++++++++++
 tb/tb_load_store_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, alignment helpers.
// Latency: none (package only).
// Backpressure: n/a.
package load_store_unit_pkg;

  // ReqSize encodings; 2'b11 is accepted and handled as a word access.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } lsuStateT;

  // Both SIZE_W and the reserved 2'b11 code are word accesses.
  function automatic logic isWordSize(input logic [1:0] size);
    return size[1];
  endfunction

  // Natural-alignment violation: odd halfword address or non-zero word offset.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] low);
    if (isWordSize(size)) return (low != 2'b00);
    if (size == SIZE_H)   return low[0];
    return 1'b0;
  endfunction

  // Force-align the low address bits to the access size.
  function automatic logic [1:0] alignLow(input logic [1:0] size, input logic [1:0] low);
    if (isWordSize(size)) return 2'b00;
    if (size == SIZE_H)   return {low[1], 1'b0};
    return low;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Lane steering for the load/store unit: load extraction/extension and store lane merge.
// Latency: purely combinational.
// Backpressure: none; outputs follow inputs.
// Ports: addrLow/size/isUnsigned select lanes; loadWord -> loadData (extended);
//        mergeWord + storeData -> mergeData (full word to write back).
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  addrLow,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  input  logic [31:0] loadWord,
  input  logic [31:0] mergeWord,
  input  logic [31:0] storeData,
  output logic [31:0] loadData,
  output logic [31:0] mergeData
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
  assign byteSel = loadWord[{addrLow, 3'b000} +: 8];
  assign halfSel = loadWord[{addrLow[1], 4'b0000} +: 16];

  always_comb begin
    loadData = loadWord;
    case (size)
      SIZE_B:  loadData = {{24{~isUnsigned & byteSel[7]}}, byteSel};
      SIZE_H:  loadData = {{16{~isUnsigned & halfSel[15]}}, halfSel};
      default: loadData = loadWord;
    endcase
  end

  always_comb begin
    mergeData = mergeWord;
    case (size)
      SIZE_B:  mergeData[{addrLow, 3'b000} +: 8]    = storeData[7:0];
      SIZE_H:  mergeData[{addrLow[1], 4'b0000} +: 16] = storeData[15:0];
      default: mergeData = storeData;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator: word-aligned memory accesses, RMW for sub-word stores, extended load data.
// Latency: load/word store respond 2 cycles after acceptance, sub-word store 3; +1 per cycle ReadReady is low.
// Backpressure: ReqReady is high only in IDLE; no response backpressure (RespValid is a 1-cycle pulse).
// Ports: Req* = pipeline request, Resp* = completion, Read*/Write* = DataMemory port.
// Option: define LSU_MISALIGN_EXC_EN to flag misaligned half/word accesses instead of force-aligning them.
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqUnsigned,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        RespMisalign,
  output logic        ReadValid,
  output logic [31:0] ReadAddr,
  input  logic [31:0] ReadData,
  input  logic        ReadReady,
  output logic        WriteValid,
  output logic [31:0] WriteAddr,
  output logic [31:0] WriteData
);

  lsuStateT    state, nextState;
  logic [31:0] addrQ, wDataQ, rDataQ, respDataQ;
  logic [1:0]  sizeQ;
  logic        unsignedQ, writeQ;
  logic        accept, reqMisalign;
  logic [31:0] effAddr;
  logic [31:0] loadData, mergeData;

  assign accept = (state == ST_IDLE) && ReqValid;

`ifdef LSU_MISALIGN_EXC_EN
  logic misalignQ;
  // Misaligned requests never touch memory, so the raw address is kept.
  assign reqMisalign = isMisaligned(ReqSize, ReqAddr[1:0]);
  assign effAddr     = ReqAddr;
`else
  assign reqMisalign = 1'b0;
  assign effAddr     = {ReqAddr[31:2], alignLow(ReqSize, ReqAddr[1:0])};
`endif

  lsu_lane_align uLaneAlign (
    .addrLow    (addrQ[1:0]),
    .size       (sizeQ),
    .isUnsigned (unsignedQ),
    .loadWord   (ReadData),
    .mergeWord  (rDataQ),
    .storeData  (wDataQ),
    .loadData   (loadData),
    .mergeData  (mergeData)
  );

  // State register
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= ST_IDLE;
    else       state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      ST_IDLE: begin
        if (ReqValid) begin
          if (reqMisalign)                          nextState = ST_RESP;
          else if (ReqWrite && isWordSize(ReqSize)) nextState = ST_WR;
          else                                      nextState = ST_RD;
        end
      end
      ST_RD:   if (ReadReady) nextState = writeQ ? ST_WR : ST_RESP;
      ST_WR:   nextState = ST_RESP;
      default: nextState = ST_IDLE;
    endcase
  end

  // Outputs decode from the state register, so an async reset drops strobes immediately.
  always_comb begin
    ReqReady   = (state == ST_IDLE);
    ReadValid  = (state == ST_RD);
    WriteValid = (state == ST_WR);
    RespValid  = (state == ST_RESP);
    ReadAddr   = ReadValid  ? {addrQ[31:2], 2'b00} : 32'd0;
    WriteAddr  = WriteValid ? {addrQ[31:2], 2'b00} : 32'd0;
    WriteData  = WriteValid ? mergeData : 32'd0;
    RespData   = respDataQ;
`ifdef LSU_MISALIGN_EXC_EN
    RespMisalign = RespValid && misalignQ;
`else
    RespMisalign = 1'b0;
`endif
  end

  // Request latch, read capture and registered response data.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      addrQ     <= '0;
      wDataQ    <= '0;
      rDataQ    <= '0;
      respDataQ <= '0;
      sizeQ     <= SIZE_B;
      unsignedQ <= 1'b0;
      writeQ    <= 1'b0;
    end else begin
      if (accept) begin
        addrQ     <= effAddr;
        sizeQ     <= ReqSize;
        unsignedQ <= ReqUnsigned;
        wDataQ    <= ReqWData;
        writeQ    <= ReqWrite;
        if (reqMisalign) respDataQ <= '0;
      end
      if ((state == ST_RD) && ReadReady) begin
        rDataQ <= ReadData;
        if (!writeQ) respDataQ <= loadData;
      end
      if (state == ST_WR) respDataQ <= '0;
    end
  end

`ifdef LSU_MISALIGN_EXC_EN
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)       misalignQ <= 1'b0;
    else if (accept) misalignQ <= reqMisalign;
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural word memory.
// Latency: n/a.
// Backpressure: ReadReady is withheld through readStall to stretch the RD state.
module tb_load_store_unit;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        ReqValid, ReqReady, ReqWrite, ReqUnsigned;
  logic [1:0]  ReqSize;
  logic [31:0] ReqAddr, ReqWData;
  logic        RespValid, RespMisalign;
  logic [31:0] RespData;
  logic        ReadValid, ReadReady, WriteValid;
  logic [31:0] ReadAddr, ReadData, WriteAddr, WriteData;

  logic [31:0] mem [0:255];
  logic        readStall;

  int checks = 0;
  int errors = 0;
  int rdCycles = 0;
  int wrCycles = 0;
  logic [31:0] lastRdAddr = 32'd0;
  logic [31:0] lastWrAddr = 32'd0;
  logic [31:0] lastWrData = 32'd0;

  always #5 CLK = ~CLK;

  load_store_unit dut (
    .CLK(CLK), .RSTn(RSTn),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite), .ReqSize(ReqSize),
    .ReqUnsigned(ReqUnsigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
    .RespValid(RespValid), .RespData(RespData), .RespMisalign(RespMisalign),
    .ReadValid(ReadValid), .ReadAddr(ReadAddr), .ReadData(ReadData), .ReadReady(ReadReady),
    .WriteValid(WriteValid), .WriteAddr(WriteAddr), .WriteData(WriteData)
  );

  // Memory model: combinational read, write lands on the edge ending the WR cycle.
  assign ReadReady = ReadValid && !readStall;
  assign ReadData  = mem[ReadAddr[9:2]];
  always @(posedge CLK) if (WriteValid) mem[WriteAddr[9:2]] <= WriteData;

  always @(negedge CLK) begin
    if (ReadValid)  begin rdCycles++; lastRdAddr = ReadAddr; end
    if (WriteValid) begin wrCycles++; lastWrAddr = WriteAddr; lastWrData = WriteData; end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request; stall = number of edges with ReadReady held 0 in RD.
  task automatic doReq(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, input int stall,
                       output int lat, output logic [31:0] data, output logic mis,
                       output int nRd, output int nWr);
    int rd0, wr0;
    @(negedge CLK);
    check("ready_before_req", {31'd0, ReqReady}, 32'd1);
    ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqUnsigned = uns;
    ReqAddr = addr; ReqWData = wd; readStall = (stall > 0);
    @(posedge CLK);
    #1 ReqValid = 1'b0;
    rd0 = rdCycles; wr0 = wrCycles;
    lat = 0;
    while (lat < 60) begin
      @(negedge CLK);
      lat++;
      if (stall > 0 && lat <= stall + 1) begin
        check("stall_readvalid", {31'd0, ReadValid}, 32'd1);
        check("stall_reqready", {31'd0, ReqReady}, 32'd0);
        if (lat == stall + 1) readStall = 1'b0;
      end
      if (RespValid) break;
    end
    data = RespData; mis = RespMisalign;
    nRd = rdCycles - rd0; nWr = wrCycles - wr0;
    @(negedge CLK);
    check("resp_one_cycle", {31'd0, RespValid}, 32'd0);
    check("ready_after_resp", {31'd0, ReqReady}, 32'd1);
  endtask

  initial begin
    int lat, nRd, nWr, w0;
    logic [31:0] d;
    logic m;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h40] = 32'h8899AABB;   // word at A = 0x100
    ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00; ReqUnsigned = 1'b0;
    ReqAddr = 32'd0; ReqWData = 32'd0; readStall = 1'b0;

    // Reset state
    #2;
    check("rst_reqready",   {31'd0, ReqReady},   32'd1);
    check("rst_respvalid",  {31'd0, RespValid},  32'd0);
    check("rst_misalign",   {31'd0, RespMisalign}, 32'd0);
    check("rst_readvalid",  {31'd0, ReadValid},  32'd0);
    check("rst_writevalid", {31'd0, WriteValid}, 32'd0);
    check("rst_respdata",   RespData,  32'd0);
    check("rst_readaddr",   ReadAddr,  32'd0);
    check("rst_writeaddr",  WriteAddr, 32'd0);
    check("rst_writedata",  WriteData, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTn = 1'b1;

    // Signed byte load at A+1
    doReq(1'b0, 2'b00, 1'b0, 32'h101, 32'd0, 0, lat, d, m, nRd, nWr);
    check("lb_a1_data", d, 32'hFFFFFFAA);
    check("lb_a1_lat", lat, 32'd2);
    check("lb_a1_rdaddr", lastRdAddr, 32'h100);
    check("lb_a1_nrd", nRd, 32'd1);

    // Half loads at A+2
    doReq(1'b0, 2'b01, 1'b1, 32'h102, 32'd0, 0, lat, d, m, nRd, nWr);
    check("lhu_a2_data", d, 32'h00008899);
    doReq(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, 0, lat, d, m, nRd, nWr);
    check("lh_a2_data", d, 32'hFFFF8899);
    doReq(1'b0, 2'b00, 1'b1, 32'h100, 32'd0, 0, lat, d, m, nRd, nWr);
    check("lbu_a0_data", d, 32'h000000BB);
    doReq(1'b0, 2'b00, 1'b0, 32'h102, 32'd0, 0, lat, d, m, nRd, nWr);
    check("lb_a2_data", d, 32'hFFFFFF99);

    // Byte store 0x12 at A+3 (RMW)
    doReq(1'b1, 2'b00, 1'b0, 32'h103, 32'hFFFFFF12, 0, lat, d, m, nRd, nWr);
    check("sb_nrd", nRd, 32'd1);
    check("sb_nwr", nWr, 32'd1);
    check("sb_wdata", lastWrData, 32'h1299AABB);
    check("sb_waddr", lastWrAddr, 32'h100);
    check("sb_lat", lat, 32'd3);
    check("sb_respdata", d, 32'd0);

    // Word load sees the merged value; RespData holds afterwards
    doReq(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 0, lat, d, m, nRd, nWr);
    check("lw_after_sb", d, 32'h1299AABB);
    repeat (3) @(negedge CLK);
    check("respdata_hold", RespData, 32'h1299AABB);

    // Half store 0xCAFE at A+2
    doReq(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234CAFE, 0, lat, d, m, nRd, nWr);
    check("sh_wdata", lastWrData, 32'hCAFEAABB);
    check("sh_nwr", nWr, 32'd1);

    // Word load with ReadReady held 0 for 3 cycles
    doReq(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 3, lat, d, m, nRd, nWr);
    check("stall_data", d, 32'hCAFEAABB);
    check("stall_lat", lat, 32'd5);
    check("stall_nrd", nRd, 32'd4);

    // Word store, no read phase
    doReq(1'b1, 2'b11, 1'b0, 32'h104, 32'h11223344, 0, lat, d, m, nRd, nWr);
    check("sw_lat", lat, 32'd2);
    check("sw_nrd", nRd, 32'd0);
    check("sw_wdata", lastWrData, 32'h11223344);
    doReq(1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 0, lat, d, m, nRd, nWr);
    check("lw_after_sw", d, 32'h11223344);

    // Misaligned word load at A+2
    doReq(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, 0, lat, d, m, nRd, nWr);
`ifdef LSU_MISALIGN_EXC_EN
    check("mis_flag", {31'd0, m}, 32'd1);
    check("mis_data", d, 32'd0);
    check("mis_nrd", nRd, 32'd0);
    check("mis_lat", lat, 32'd1);
`else
    check("mis_flag", {31'd0, m}, 32'd0);
    check("mis_data", d, 32'hCAFEAABB);
    check("mis_rdaddr", lastRdAddr, 32'h100);
    check("mis_lat", lat, 32'd2);
`endif

    // Reset pulsed during WR of a word store
    @(negedge CLK);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqUnsigned = 1'b0;
    ReqAddr = 32'h108; ReqWData = 32'hDEADBEEF;
    @(posedge CLK);
    #1 ReqValid = 1'b0;
    @(negedge CLK);
    check("rstwr_in_wr", {31'd0, WriteValid}, 32'd1);
    #1 RSTn = 1'b0;
    #1;
    check("rstwr_writevalid", {31'd0, WriteValid}, 32'd0);
    check("rstwr_reqready",   {31'd0, ReqReady},   32'd1);
    check("rstwr_writeaddr",  WriteAddr, 32'd0);
    check("rstwr_writedata",  WriteData, 32'd0);
    check("rstwr_respdata",   RespData,  32'd0);
    check("rstwr_respvalid",  {31'd0, RespValid}, 32'd0);
    w0 = wrCycles;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTn = 1'b1;
    #1 check("rstwr_ready_release", {31'd0, ReqReady}, 32'd1);
    repeat (3) @(negedge CLK);
    check("rstwr_no_write", wrCycles, w0);
    check("rstwr_mem_intact", mem[8'h42], 32'd0);
    doReq(1'b0, 2'b10, 1'b0, 32'h108, 32'd0, 0, lat, d, m, nRd, nWr);
    check("rstwr_load_back", d, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
